// File: rtl/param_assoc_cache.sv
// Set-associative write-back, write-allocate cache with multi-word lines.
// Refill and write-back move one word per load/store/complete handshake.
module param_assoc_cache #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Enable,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] write_data,
    input  logic        complete,
    input  logic [31:0] load_data,
    output logic        load,
    output logic        store,
    output logic        cache_hit,
    output logic [31:0] read_data,
    output logic [31:0] store_data,
    output logic [31:0] addr_out
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int CW  = (OFF == 0) ? 1 : OFF;
    localparam int TW  = 30 - OFF - IDX;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
    state_t state, stateNext;

    logic [TW-1:0]   tagArr   [WAYS][SETS];
    logic [31:0]     dataArr  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0] validArr [SETS];
    logic [WAYS-1:0] dirtyArr [SETS];
    logic [SETS-1:0] lru;

    logic [CW-1:0]  reqWord, cnt;
    logic [IDX-1:0] reqIdx, mIdx;
    logic [TW-1:0]  reqTag, mTag, vicTag;
    logic           vicWay, vicSel, hitWay, hitAny;
    logic           req, hit, missStart, hitUpd, lastWord;

    assign reqWord = CW'((addr_in >> 2) & 32'(LINE_WORDS - 1));
    assign reqIdx  = IDX'(addr_in >> (OFF + 2));
    assign reqTag  = TW'(addr_in >> (OFF + IDX + 2));

    function automatic logic otherWay(input logic w);
        return (WAYS == 2) ? ~w : 1'b0;
    endfunction

    // Lowest matching way wins; an invalid way is preferred as victim over the LRU way.
    always_comb begin
        hitAny = 1'b0;
        hitWay = 1'b0;
        vicSel = (WAYS == 2) ? lru[reqIdx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validArr[reqIdx][w] && tagArr[w][reqIdx] == reqTag) begin
                hitAny = 1'b1;
                hitWay = 1'(w);
            end
            if (!validArr[reqIdx][w]) vicSel = 1'(w);
        end
    end

    assign req       = read_in | write_in;
    assign hit       = req && (state == IDLE) && hitAny;
    assign cache_hit = ~req | hit;
    assign read_data = (hit && !write_in) ? dataArr[hitWay][reqIdx][reqWord] : 32'h0;
    assign missStart = (state == IDLE) && req && !hitAny && Enable;
    assign hitUpd    = hit && Enable;
    assign lastWord  = (cnt == CW'(LINE_WORDS - 1));

    always_comb begin
        stateNext  = state;
        load       = 1'b0;
        store      = 1'b0;
        addr_out   = 32'h0;
        store_data = 32'h0;
        case (state)
            IDLE: if (missStart)
                stateNext = (validArr[reqIdx][vicSel] && dirtyArr[reqIdx][vicSel]) ? WB : FILL;
            WB: begin
                store      = 1'b1;
                addr_out   = (32'(vicTag) << (OFF + IDX + 2)) | (32'(mIdx) << (OFF + 2)) | (32'(cnt) << 2);
                store_data = dataArr[vicWay][mIdx][cnt];
                if (complete && lastWord) stateNext = FILL;
            end
            FILL: begin
                load     = 1'b1;
                addr_out = (32'(mTag) << (OFF + IDX + 2)) | (32'(mIdx) << (OFF + 2)) | (32'(cnt) << 2);
                if (complete && lastWord) stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mIdx   <= '0;
            mTag   <= '0;
            vicTag <= '0;
            vicWay <= 1'b0;
            lru    <= '0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
            end
        end else begin
            state <= stateNext;
            if (missStart) begin
                mIdx   <= reqIdx;
                mTag   <= reqTag;
                vicWay <= vicSel;
                vicTag <= tagArr[vicSel][reqIdx];
                cnt    <= '0;
            end
            if (hitUpd) begin
                lru[reqIdx] <= otherWay(hitWay);
                if (write_in) dirtyArr[reqIdx][hitWay] <= 1'b1;
            end
            if ((state == WB || state == FILL) && complete)
                cnt <= lastWord ? '0 : cnt + CW'(1);
            if (state == WB && complete && lastWord)
                dirtyArr[mIdx][vicWay] <= 1'b0;
            if (state == FILL && complete && lastWord) begin
                validArr[mIdx][vicWay] <= 1'b1;
                dirtyArr[mIdx][vicWay] <= 1'b0;
                lru[mIdx]              <= otherWay(vicWay);
            end
        end
    end

    // Line storage carries no reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hitUpd && write_in)
                dataArr[hitWay][reqIdx][reqWord] <= write_data;
            if (state == FILL && complete)
                dataArr[vicWay][mIdx][cnt] <= load_data;
            if (state == FILL && complete && lastWord)
                tagArr[vicWay][mIdx] <= mTag;
        end
    end

endmodule
